mix_columns_iter: RTL and testbench

Iterative, handshaked AES (Inverse) MixColumns engine. It accepts one 128-bit state and processes `COLS_PER_CYCLE` 32-bit columns per clock, in either forward (encrypt) or inverse (decrypt) mode. The result is returned through a registered valid/ready output. It sits between ShiftRows/AddRoundKey in the round datapath and replaces the purely combinational column mixer. Area and throughput are traded via the parameter.

---
 rtl/mix_columns_iter_pkg.sv | 44 ++++
 rtl/mix_columns_iter_word.sv | 37 +++
 rtl/mix_columns_iter.sv | 113 +++++++++++
 tb/tb_mix_columns_iter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_columns_iter_pkg.sv
// Shared AES helpers for the iterative MixColumns engine: GF(2^8) constant
// multipliers, FSM state type and column slicing constants.
package aes_pkg;

   localparam logic [7:0] AES_POLY  = 8'h1B;
   localparam int         NUM_COLS  = 4;
   localparam int         COL_W     = 32;
   localparam int         BYTE_W    = 8;
   localparam int         STATE_W   = NUM_COLS * COL_W;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } mc_state_t;

   // MSB index of column c inside a 128-bit state; column 0 is the top word.
   function automatic int col_msb(input int c);
      return STATE_W - 1 - COL_W * c;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
   endfunction

   // Only the coefficients used by (Inv)MixColumns are supported.
   function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      case (k)
         8'h01:   return a;
         8'h02:   return x2;
         8'h03:   return x2 ^ a;
         8'h09:   return x8 ^ a;
         8'h0b:   return x8 ^ x2 ^ a;
         8'h0d:   return x8 ^ x4 ^ a;
         8'h0e:   return x8 ^ x4 ^ x2;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/mix_columns_iter_word.sv
// Combinational mixer for one 32-bit column, forward or inverse.
module mix_column_word
   import aes_pkg::*;
(
   input  logic [COL_W-1:0] col_in,
   input  logic             decrypt,
   output logic [COL_W-1:0] col_out
);

   logic [7:0] a    [NUM_COLS];
   logic [7:0] coef [NUM_COLS];

   // Each row uses the same circulant coefficient row, rotated by its index.
   always_comb begin
      col_out = '0;
      for (int r = 0; r < NUM_COLS; r++) begin
         a[r] = col_in[COL_W-1-BYTE_W*r -: BYTE_W];
      end
      if (decrypt) begin
         coef[0] = 8'h0e;
         coef[1] = 8'h0b;
         coef[2] = 8'h0d;
         coef[3] = 8'h09;
      end else begin
         coef[0] = 8'h02;
         coef[1] = 8'h03;
         coef[2] = 8'h01;
         coef[3] = 8'h01;
      end
      for (int r = 0; r < NUM_COLS; r++) begin
         for (int j = 0; j < NUM_COLS; j++) begin
            col_out[COL_W-1-BYTE_W*r -: BYTE_W] ^= gf_mul_const(a[(r + j) % NUM_COLS], coef[j]);
         end
      end
   end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative handshaked (Inv)MixColumns: mixes COLS_PER_CYCLE columns of the
// work register per RUN cycle and presents the result from a register.
module mix_columns_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_decrypt,
   input  logic [STATE_W-1:0] IN_DATA,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] MIXED_DATA,
   output logic               busy
);

   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] COL_STEP = COLS_PER_CYCLE[1:0];
   localparam logic [1:0] LAST_COL = 2'(NUM_COLS - COLS_PER_CYCLE);

   mc_state_t          state_q, state_d;
   logic [1:0]         col_q, col_d;
   logic               mode_q, mode_d;
   logic [STATE_W-1:0] work_q, work_d;

   logic [COL_W-1:0]   mix_in  [COLS_PER_CYCLE];
   logic [COL_W-1:0]   mix_out [COLS_PER_CYCLE];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
      if (COLS_PER_CYCLE == NUM_COLS) begin : g_full
         assign mix_in[g] = work_q[col_msb(g) -: COL_W];
      end else begin : g_sel
         always_comb begin
            mix_in[g] = work_q[col_msb(int'(col_q) + g) -: COL_W];
         end
      end

      mix_column_word u_word (
         .col_in  (mix_in[g]),
         .decrypt (mode_q),
         .col_out (mix_out[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         mode_q  <= 1'b0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         mode_q  <= mode_d;
         work_q  <= work_d;
      end
   end

   // DONE overlaps with the next accept so a ready consumer sees N+1 cadence.
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      mode_d   = mode_q;
      work_d   = work_q;
      in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = IN_DATA;
               mode_d  = in_decrypt;
               col_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int g = 0; g < COLS_PER_CYCLE; g++) begin
               work_d[col_msb(int'(col_q) + g) -: COL_W] = mix_out[g];
            end
            if (col_q == LAST_COL) begin
               col_d   = '0;
               state_d = DONE;
            end else begin
               col_d = col_q + COL_STEP;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (in_valid) begin
                  work_d  = IN_DATA;
                  mode_d  = in_decrypt;
                  col_d   = '0;
                  state_d = RUN;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid  = (state_q == DONE);
   assign MIXED_DATA = work_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: one instance per legal COLS_PER_CYCLE, checked
// against a generic GF(2^8) matrix-multiply reference model.
module tb_mix_columns_iter;

   logic         clk;
   logic         rst;
   logic         in_valid   [3];
   logic         in_ready   [3];
   logic         in_decrypt [3];
   logic [127:0] in_data    [3];
   logic         out_valid  [3];
   logic         out_ready  [3];
   logic [127:0] mixed      [3];
   logic         busy       [3];

   int checks;
   int errors;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .in_decrypt (in_decrypt[g]),
         .IN_DATA    (in_data[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .MIXED_DATA (mixed[g]),
         .busy       (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Generic shift-and-add multiply over the AES field.
   function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic       hi;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         hi = a[7];
         a  = a << 1;
         if (hi) a ^= 8'h1b;
      end
      return p;
   endfunction

   function automatic logic [31:0] refColumn(input logic [31:0] w, input logic dec);
      logic [7:0] m [4];
      logic [7:0] a [4];
      logic [31:0] r = '0;
      if (dec) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int i = 0; i < 4; i++) a[i] = w[31-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b = 8'h00;
         for (int j = 0; j < 4; j++) b ^= refMul(a[(i + j) % 4], m[j]);
         r[31-8*i -: 8] = b;
      end
      return r;
   endfunction

   function automatic logic [127:0] refState(input logic [127:0] s, input logic dec);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = refColumn(s[127-32*c -: 32], dec);
      return r;
   endfunction

   function automatic logic [127:0] randState();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called just after a rising edge; returns the result and the edge count
   // from the accepting edge to out_valid.
   task automatic applyStimulus(input int k, input logic [127:0] data, input logic dec,
                                input bit toggle, output logic [127:0] result, output int lat);
      int n = 0;
      in_data[k]    = data;
      in_decrypt[k] = dec;
      in_valid[k]   = 1'b1;
      while (!in_ready[k] && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      @(posedge clk); #1;
      in_valid[k] = 1'b0;
      lat = 0;
      while (!out_valid[k] && lat < 50) begin
         if (toggle) in_decrypt[k] = ~in_decrypt[k];
         @(posedge clk); #1;
         lat++;
      end
      result       = mixed[k];
      out_ready[k] = 1'b1;
      @(posedge clk); #1;
      out_ready[k] = 1'b0;
   endtask

   task automatic streamTest(input int k);
      logic [127:0] q [$];
      int got  = 0;
      bit done = 0;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               logic [127:0] x = randState();
               logic         d = 1'($urandom_range(0, 1));
               bit           acc = 0;
               int           guard = 0;
               for (int w = $urandom_range(0, 2); w > 0; w--) begin
                  @(posedge clk); #1;
               end
               in_data[k]    = x;
               in_decrypt[k] = d;
               in_valid[k]   = 1'b1;
               while (!acc && guard < 200) begin
                  @(negedge clk);
                  acc = in_ready[k];
                  @(posedge clk); #1;
                  guard++;
               end
               if (acc) q.push_back(refState(x, d));
               in_valid[k] = 1'b0;
            end
            done = 1;
         end
         begin
            int cyc = 0;
            while (got < 100 && cyc < 5000) begin
               out_ready[k] = 1'($urandom_range(0, 1));
               @(negedge clk);
               if (out_valid[k] && out_ready[k]) begin
                  if (q.size() > 0) checkOutput($sformatf("stream%0d_data", k), mixed[k], q.pop_front());
                  else              checkOutput($sformatf("stream%0d_underflow", k), 128'(q.size()), 128'd1);
                  got++;
               end
               @(posedge clk); #1;
               cyc++;
            end
            out_ready[k] = 1'b0;
         end
      join
      checkOutput($sformatf("stream%0d_count", k), 128'(got), 128'd100);
      checkOutput($sformatf("stream%0d_left", k), 128'(q.size()), 128'd0);
      checkOutput($sformatf("stream%0d_producer", k), 128'(done), 128'd1);
   endtask

   initial begin
      logic [127:0] res, res2, x, y, held;
      int           lat;
      int           bad;

      checks = 0;
      errors = 0;
      rst    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid[k]   = 1'b0;
         in_decrypt[k] = 1'b0;
         in_data[k]    = '0;
         out_ready[k]  = 1'b0;
      end
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("rst%0d_in_ready", k), 128'(in_ready[k]), 128'd1);
         checkOutput($sformatf("rst%0d_out_valid", k), 128'(out_valid[k]), 128'd0);
         checkOutput($sformatf("rst%0d_busy", k), 128'(busy[k]), 128'd0);
         checkOutput($sformatf("rst%0d_data", k), mixed[k], 128'd0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Forward known vector, one column per cycle.
      applyStimulus(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 0, res, lat);
      checkOutput("fwd_c1_data", res, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
      checkOutput("fwd_c1_latency", 128'(lat), 128'd4);

      // Inverse known column, two columns per cycle.
      x = {32'hd5d5d7d6, randState()[95:0]};
      applyStimulus(1, x, 1'b1, 0, res, lat);
      checkOutput("inv_c2_col0", 128'(res[127:96]), 128'(32'hd4d4d4d5));
      checkOutput("inv_c2_data", res, refState(x, 1'b1));
      checkOutput("inv_c2_latency", 128'(lat), 128'd2);

      // Round trip over random states, counted as one comparison per state.
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         x = randState();
         applyStimulus(1, x, 1'b1, 0, res, lat);
         applyStimulus(1, res, 1'b0, 0, res2, lat);
         checkOutput($sformatf("roundtrip_%0d", i), res2, x);
      end

      // Backpressure with a competing input held high, four columns per cycle.
      x = randState();
      y = randState();
      in_data[2] = x; in_decrypt[2] = 1'b0; in_valid[2] = 1'b1;
      @(posedge clk); #1;
      in_data[2] = y; in_decrypt[2] = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_first_valid", 128'(out_valid[2]), 128'd1);
      checkOutput("bp_first_data", mixed[2], refState(x, 1'b0));
      held = mixed[2];
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (mixed[2] !== held || !out_valid[2] || in_ready[2]) bad++;
      end
      checkOutput("bp_hold_stable", 128'(bad), 128'd0);
      out_ready[2] = 1'b1;
      #1;
      checkOutput("bp_in_ready", 128'(in_ready[2]), 128'd1);
      @(posedge clk); #1;
      out_ready[2] = 1'b0;
      in_valid[2]  = 1'b0;
      checkOutput("bp_accept_run", 128'(out_valid[2]), 128'd0);
      @(posedge clk); #1;
      checkOutput("bp_second_valid", 128'(out_valid[2]), 128'd1);
      checkOutput("bp_second_data", mixed[2], refState(y, 1'b1));
      out_ready[2] = 1'b1;
      @(posedge clk); #1;
      out_ready[2] = 1'b0;

      // Mode is latched at accept even when in_decrypt toggles during RUN.
      x = {32'hdb135345, randState()[95:0]};
      applyStimulus(0, x, 1'b0, 1, res, lat);
      checkOutput("mode_latch_col0", 128'(res[127:96]), 128'(32'h8e4da1bc));
      checkOutput("mode_latch_data", res, refState(x, 1'b0));

      // Reset in the middle of RUN discards the state.
      x = randState();
      in_data[0] = x; in_decrypt[0] = 1'b0; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_ready", 128'(in_ready[0]), 128'd1);
      checkOutput("midrst_out_valid", 128'(out_valid[0]), 128'd0);
      checkOutput("midrst_data", mixed[0], 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("midrst_no_valid", 128'(out_valid[0]), 128'd0);
      y = randState();
      applyStimulus(0, y, 1'b1, 0, res, lat);
      checkOutput("midrst_fresh_data", res, refState(y, 1'b1));
      checkOutput("midrst_fresh_latency", 128'(lat), 128'd4);

      for (int k = 0; k < 3; k++) streamTest(k);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
